fft_peak_detect: RTL and testbench

//  Downstream consumer of the 32-point pipelined FFT. Takes the FFT output bin stream
//  (16-bit signed re/im, one bin per qualified cycle, natural order 0..N-1).

---
 rtl/fft_peak_detect_if.sv | 26 ++
 rtl/fft_peak_detect.sv | 122 ++++++++++++
 tb/tb_fft_peak_detect.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_if.sv
// Bin stream into the peak detector and the magnitude/peak report stream out of it.
interface fft_peak_detect_if #(
  parameter int DW    = 16,
  parameter int IDX_W = 5
);
  logic                 in_valid;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic                 mag_valid;
  logic [2*DW-1:0]      mag_out;
  logic [IDX_W-1:0]     mag_idx;
  logic                 peak_valid;
  logic [IDX_W-1:0]     peak_idx;
  logic [2*DW-1:0]      peak_mag;
  logic                 det;

  modport master (
    output in_valid, din_r, din_i,
    input  mag_valid, mag_out, mag_idx, peak_valid, peak_idx, peak_mag, det
  );

  modport slave (
    input  in_valid, din_r, din_i,
    output mag_valid, mag_out, mag_idx, peak_valid, peak_idx, peak_mag, det
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Squared-magnitude stream and per-frame peak report for the pipelined FFT bin output.
// S1 registers the two squares, S2 registers their sum and runs the running-max search.
module fft_peak_detect #(
  parameter int          N       = 32,
  parameter int          IDX_W   = 5,
  parameter int          DW      = 16,
  parameter bit          SKIP_DC = 1'b0,
  parameter logic [31:0] THRESH  = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic             busy_o,
  fft_peak_detect_if.slave bus
);
  localparam int MW = 2 * DW;
  localparam int CW = (MW > 32) ? MW : 32;
  localparam logic [IDX_W-1:0] FIRST_IDX = SKIP_DC ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 s1Valid_q;
  logic [IDX_W-1:0]     s1Idx_q;
  logic [MW-1:0]        re2_q, im2_q, re2_d, im2_d;
  logic                 magValid_q;
  logic [MW-1:0]        magOut_q;
  logic [IDX_W-1:0]     magIdx_q;
  logic [MW-1:0]        max_q, max_d;
  logic [IDX_W-1:0]     maxIdx_q, maxIdx_d;
  logic                 peakValid_q;
  logic [IDX_W-1:0]     peakIdx_q;
  logic [MW-1:0]        peakMag_q;
  logic                 det_q, det_d;
  logic signed [MW-1:0] reExt, imExt;
  logic [MW-1:0]        sum_d;
  logic                 isFirst, isLast, win;

  // Squares are carried at the full 2*DW width: (-2^(DW-1))^2 needs 2*DW-1 bits, so the
  // sum never overflows and needs no saturation.
  always_comb begin
    reExt    = MW'(bus.din_r);
    imExt    = MW'(bus.din_i);
    re2_d    = reExt * reExt;
    im2_d    = imExt * imExt;
    cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    sum_d    = re2_q + im2_q;
    isFirst  = (s1Idx_q == FIRST_IDX);
    isLast   = (s1Idx_q == LAST_IDX);
    win      = !(SKIP_DC && (s1Idx_q == '0)) && (isFirst || (sum_d > max_q));
    max_d    = win ? sum_d : max_q;
    maxIdx_d = win ? s1Idx_q : maxIdx_q;
    det_d    = CW'(max_d) > CW'(THRESH);
  end

  // Strict '>' keeps the lower index on ties; the winner including the last bin is
  // reported in the same cycle its own magnitude leaves S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1Valid_q   <= 1'b0;
      s1Idx_q     <= '0;
      re2_q       <= '0;
      im2_q       <= '0;
      magValid_q  <= 1'b0;
      magOut_q    <= '0;
      magIdx_q    <= '0;
      max_q       <= '0;
      maxIdx_q    <= '0;
      peakValid_q <= 1'b0;
      peakIdx_q   <= '0;
      peakMag_q   <= '0;
      det_q       <= 1'b0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1Valid_q   <= 1'b0;
      magValid_q  <= 1'b0;
      max_q       <= '0;
      maxIdx_q    <= '0;
      peakValid_q <= 1'b0;
    end else begin
      s1Valid_q   <= bus.in_valid;
      magValid_q  <= s1Valid_q;
      peakValid_q <= 1'b0;
      if (bus.in_valid) begin
        s1Idx_q <= cnt_q;
        re2_q   <= re2_d;
        im2_q   <= im2_d;
        cnt_q   <= cnt_d;
      end
      if (s1Valid_q) begin
        magOut_q <= sum_d;
        magIdx_q <= s1Idx_q;
        max_q    <= max_d;
        maxIdx_q <= maxIdx_d;
        if (isFirst) begin
          state_q <= ACC;
        end
        if (isLast && (state_q == ACC)) begin
          state_q     <= IDLE;
          peakValid_q <= 1'b1;
          peakIdx_q   <= maxIdx_d;
          peakMag_q   <= max_d;
          det_q       <= det_d;
        end
      end
    end
  end

  assign busy_o         = (state_q == ACC) | s1Valid_q | magValid_q;
  assign bus.mag_valid  = magValid_q;
  assign bus.mag_out    = magOut_q;
  assign bus.mag_idx    = magIdx_q;
  assign bus.peak_valid = peakValid_q;
  assign bus.peak_idx   = peakIdx_q;
  assign bus.peak_mag   = peakMag_q;
  assign bus.det        = det_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: two instances (plain, and SKIP_DC=1/THRESH=1000) share one
// stimulus stream; a frame-level model predicts every magnitude and peak report.
module tb_fft_peak_detect;
  localparam int N     = 32;
  localparam int IDX_W = 5;
  localparam int DW    = 16;

  typedef struct { int dut; int idx; logic [31:0] mag; int cyc; } magEv_t;
  typedef struct { int dut; int idx; logic [31:0] mag; logic det; int cyc; } peakEv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic busyA, busyB;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lastStamp = 0;
  int   lastBinStamp = 0;
  int   lastIdx [2];
  logic [31:0] lastMag [2];
  logic        lastDet [2];
  logic signed [DW-1:0] frRe [N];
  logic signed [DW-1:0] frIm [N];
  magEv_t  magQ [$];
  peakEv_t peakQ [$];

  fft_peak_detect_if #(.DW(DW), .IDX_W(IDX_W)) busA ();
  fft_peak_detect_if #(.DW(DW), .IDX_W(IDX_W)) busB ();

  fft_peak_detect #(.N(N), .IDX_W(IDX_W), .DW(DW), .SKIP_DC(1'b0), .THRESH(32'd0)) dutA (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busyA), .bus(busA.slave));
  fft_peak_detect #(.N(N), .IDX_W(IDX_W), .DW(DW), .SKIP_DC(1'b1), .THRESH(32'd1000)) dutB (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busyB), .bus(busB.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of everything the two instances report, stamped with the cycle count.
  always @(negedge clk) begin
    if (busA.mag_valid)  magQ.push_back('{0, int'(busA.mag_idx), busA.mag_out, cyc});
    if (busB.mag_valid)  magQ.push_back('{1, int'(busB.mag_idx), busB.mag_out, cyc});
    if (busA.peak_valid) peakQ.push_back('{0, int'(busA.peak_idx), busA.peak_mag, busA.det, cyc});
    if (busB.peak_valid) peakQ.push_back('{1, int'(busB.peak_idx), busB.peak_mag, busB.det, cyc});
  end

  function automatic int magCount(input int d);
    int n = 0;
    foreach (magQ[j]) if (magQ[j].dut == d) n++;
    return n;
  endfunction

  function automatic magEv_t magAt(input int d, input int n);
    magEv_t e = '{-1, -1, '0, -1};
    int c = 0;
    foreach (magQ[j]) if (magQ[j].dut == d) begin
      if (c == n) e = magQ[j];
      c++;
    end
    return e;
  endfunction

  function automatic int peakCount(input int d);
    int n = 0;
    foreach (peakQ[j]) if (peakQ[j].dut == d) n++;
    return n;
  endfunction

  function automatic peakEv_t peakAt(input int d, input int n);
    peakEv_t e = '{-1, -1, '0, 1'b0, -1};
    int c = 0;
    foreach (peakQ[j]) if (peakQ[j].dut == d) begin
      if (c == n) e = peakQ[j];
      c++;
    end
    return e;
  endfunction

  function automatic logic [31:0] refMag(input int k);
    longint r, i;
    r = frRe[k];
    i = frIm[k];
    return 32'(r * r + i * i);
  endfunction

  // Frame-level reference: scan the eligible bins, the first counted bin seeds the max.
  function automatic void refPeak(input int d, output int idx, output logic [31:0] mag,
                                  output logic det);
    int first;
    longint thr;
    first = (d == 1) ? 1 : 0;
    thr   = (d == 1) ? 1000 : 0;
    idx   = first;
    mag   = refMag(first);
    for (int k = first + 1; k < N; k++) begin
      if (refMag(k) > mag) begin
        idx = k;
        mag = refMag(k);
      end
    end
    det = (longint'(mag) > thr);
  endfunction

  function automatic logic signed [DW-1:0] randVal();
    int sel, v;
    sel = $urandom_range(0, 7);
    v   = $urandom_range(0, 6);
    case (sel)
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      2, 3, 4: return DW'(v - 3);
      default: return DW'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic clearFrame();
    for (int k = 0; k < N; k++) begin
      frRe[k] = '0;
      frIm[k] = '0;
    end
  endtask

  task automatic randomFrame();
    for (int k = 0; k < N; k++) begin
      frRe[k] = randVal();
      frIm[k] = randVal();
    end
  endtask

  task automatic driveCycle(input logic v, input logic signed [DW-1:0] r,
                            input logic signed [DW-1:0] i, input logic c);
    @(negedge clk);
    busA.in_valid = v;
    busA.din_r    = r;
    busA.din_i    = i;
    busB.in_valid = v;
    busB.din_r    = r;
    busB.din_i    = i;
    clr           = c;
    @(posedge clk);
    #1;
    lastStamp = cyc;
  endtask

  // mode 0: contiguous, 1: alternating valid plus a 10-cycle gap before bin 16, 2: random gaps
  task automatic sendFrame(input int mode);
    for (int k = 0; k < N; k++) begin
      if (mode == 1 && k == 16) repeat (10) driveCycle(1'b0, '0, '0, 1'b0);
      if (mode == 2) repeat ($urandom_range(0, 2)) driveCycle(1'b0, '0, '0, 1'b0);
      driveCycle(1'b1, frRe[k], frIm[k], 1'b0);
      if (k == N - 1) lastBinStamp = lastStamp;
      if (mode == 1) driveCycle(1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (4) driveCycle(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busA.mag_valid, busA.mag_out, busA.mag_idx, busA.peak_valid, busA.peak_idx,
         busA.peak_mag, busA.det, busyA} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_A: got %h expected 0", {busA.mag_valid, busA.mag_out,
               busA.mag_idx, busA.peak_valid, busA.peak_idx, busA.peak_mag, busA.det, busyA});
    end
    checks++;
    if ({busB.mag_valid, busB.mag_out, busB.mag_idx, busB.peak_valid, busB.peak_idx,
         busB.peak_mag, busB.det, busyB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_B: got %h expected 0", {busB.mag_valid, busB.mag_out,
               busB.mag_idx, busB.peak_valid, busB.peak_idx, busB.peak_mag, busB.det, busyB});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    int eIdx; logic [31:0] eMag; logic eDet; magEv_t m; peakEv_t p;
    clearFrame();
    frRe[5] = 16'sd100;
    frIm[5] = -16'sd100;
    magQ.delete(); peakQ.delete();
    sendFrame(0);
    drain();
    checks++;
    if ({busyA, busyB} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL impulse_busy_idle: got %b expected 00", {busyA, busyB});
    end
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      checks++;
      if (magCount(d) != N) begin
        errors++;
        $display("[TB] FAIL impulse_mag_count dut%0d: got %0d expected %0d", d, magCount(d), N);
      end
      for (int k = 0; k < N; k++) begin
        m = magAt(d, k);
        checks++;
        if (m.idx != k || m.mag !== refMag(k)) begin
          errors++;
          $display("[TB] FAIL impulse_mag dut%0d bin%0d: got (%0d,%0d) expected (%0d,%0d)",
                   d, k, m.idx, m.mag, k, refMag(k));
        end
      end
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL impulse_peak dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      checks++;
      if (p.cyc != lastBinStamp + 1 || p.cyc != magAt(d, N - 1).cyc) begin
        errors++;
        $display("[TB] FAIL impulse_peak_timing dut%0d: got cycle %0d expected %0d",
                 d, p.cyc, lastBinStamp + 1);
      end
      lastIdx[d] = eIdx; lastMag[d] = eMag; lastDet[d] = eDet;
    end
  endtask

  task automatic test_extreme_tie();
    int eIdx; logic [31:0] eMag; logic eDet; peakEv_t p;
    clearFrame();
    frRe[3] = 16'sh8000; frIm[3] = 16'sh8000;
    frRe[9] = 16'sh8000; frIm[9] = 16'sh8000;
    magQ.delete(); peakQ.delete();
    sendFrame(0);
    drain();
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL extreme_tie_peak dut%0d: got n=%0d (%0d,%h,%b) expected n=1 (%0d,%h,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      checks++;
      if (magAt(d, 9).mag !== refMag(9)) begin
        errors++;
        $display("[TB] FAIL extreme_mag9 dut%0d: got %h expected %h", d, magAt(d, 9).mag, refMag(9));
      end
      lastIdx[d] = eIdx; lastMag[d] = eMag; lastDet[d] = eDet;
    end
  endtask

  task automatic test_gaps();
    int eIdx; logic [31:0] eMag; logic eDet; peakEv_t p;
    clearFrame();
    frRe[5] = 16'sd100;
    frIm[5] = -16'sd100;
    magQ.delete(); peakQ.delete();
    sendFrame(1);
    drain();
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL gaps_peak dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      checks++;
      if (magCount(d) != N || magAt(d, N - 1).idx != N - 1) begin
        errors++;
        $display("[TB] FAIL gaps_mag_count dut%0d: got %0d expected %0d", d, magCount(d), N);
      end
      lastIdx[d] = eIdx; lastMag[d] = eMag; lastDet[d] = eDet;
    end
  endtask

  task automatic test_back_to_back();
    int eIdx [2][2]; logic [31:0] eMag [2][2]; logic eDet [2][2]; peakEv_t p0, p1;
    clearFrame();
    frRe[7] = 16'sd20;
    for (int d = 0; d < 2; d++) refPeak(d, eIdx[0][d], eMag[0][d], eDet[0][d]);
    magQ.delete(); peakQ.delete();
    sendFrame(0);
    clearFrame();
    frRe[20] = 16'sd10;
    for (int d = 0; d < 2; d++) refPeak(d, eIdx[1][d], eMag[1][d], eDet[1][d]);
    sendFrame(0);
    drain();
    for (int d = 0; d < 2; d++) begin
      p0 = peakAt(d, 0);
      p1 = peakAt(d, 1);
      checks++;
      if (peakCount(d) != 2) begin
        errors++;
        $display("[TB] FAIL b2b_peak_count dut%0d: got %0d expected 2", d, peakCount(d));
      end
      checks++;
      if (p0.idx != eIdx[0][d] || p0.mag !== eMag[0][d] || p0.det !== eDet[0][d]) begin
        errors++;
        $display("[TB] FAIL b2b_frameA dut%0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 d, p0.idx, p0.mag, p0.det, eIdx[0][d], eMag[0][d], eDet[0][d]);
      end
      checks++;
      if (p1.idx != eIdx[1][d] || p1.mag !== eMag[1][d] || p1.det !== eDet[1][d]) begin
        errors++;
        $display("[TB] FAIL b2b_frameB dut%0d: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 d, p1.idx, p1.mag, p1.det, eIdx[1][d], eMag[1][d], eDet[1][d]);
      end
      checks++;
      if (p1.cyc - p0.cyc != N) begin
        errors++;
        $display("[TB] FAIL b2b_spacing dut%0d: got %0d expected %0d", d, p1.cyc - p0.cyc, N);
      end
      lastIdx[d] = eIdx[1][d]; lastMag[d] = eMag[1][d]; lastDet[d] = eDet[1][d];
    end
  endtask

  task automatic test_clr();
    int clrStamp, nAfter; int eIdx; logic [31:0] eMag; logic eDet; peakEv_t p;
    clearFrame();
    frRe[4] = 16'sd20000;
    magQ.delete(); peakQ.delete();
    for (int k = 0; k <= 10; k++) driveCycle(1'b1, frRe[k], frIm[k], 1'b0);
    driveCycle(1'b1, 16'sd30000, '0, 1'b1);
    clrStamp = lastStamp;
    driveCycle(1'b0, '0, '0, 1'b0);
    checks++;
    if ({busyA, busyB} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clr_busy: got %b expected 00", {busyA, busyB});
    end
    checks++;
    if (int'(busA.peak_idx) != lastIdx[0] || busA.peak_mag !== lastMag[0] || busA.det !== lastDet[0]) begin
      errors++;
      $display("[TB] FAIL clr_hold_A: got (%0d,%0d,%b) expected (%0d,%0d,%b)", busA.peak_idx,
               busA.peak_mag, busA.det, lastIdx[0], lastMag[0], lastDet[0]);
    end
    checks++;
    if (int'(busB.peak_idx) != lastIdx[1] || busB.peak_mag !== lastMag[1] || busB.det !== lastDet[1]) begin
      errors++;
      $display("[TB] FAIL clr_hold_B: got (%0d,%0d,%b) expected (%0d,%0d,%b)", busB.peak_idx,
               busB.peak_mag, busB.det, lastIdx[1], lastMag[1], lastDet[1]);
    end
    clearFrame();
    frRe[2] = 16'sd30;
    sendFrame(0);
    drain();
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL clr_next_peak dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      nAfter = 0;
      foreach (magQ[j]) if (magQ[j].dut == d && magQ[j].cyc >= clrStamp) nAfter++;
      checks++;
      if (nAfter != N) begin
        errors++;
        $display("[TB] FAIL clr_mag_after dut%0d: got %0d expected %0d", d, nAfter, N);
      end
      lastIdx[d] = eIdx; lastMag[d] = eMag; lastDet[d] = eDet;
    end
  endtask

  task automatic test_skip_dc();
    int eIdx; logic [31:0] eMag; logic eDet; peakEv_t p;
    clearFrame();
    frRe[0] = 16'sd1000;
    frRe[4] = 16'sd30;
    frIm[4] = 16'sd40;
    magQ.delete(); peakQ.delete();
    sendFrame(0);
    drain();
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL skip_dc_peak dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      checks++;
      if (magAt(d, 0).idx != 0 || magAt(d, 0).mag !== refMag(0)) begin
        errors++;
        $display("[TB] FAIL skip_dc_mag0 dut%0d: got (%0d,%0d) expected (0,%0d)",
                 d, magAt(d, 0).idx, magAt(d, 0).mag, refMag(0));
      end
      lastIdx[d] = eIdx; lastMag[d] = eMag; lastDet[d] = eDet;
    end
  endtask

  task automatic test_mid_reset();
    int eIdx; logic [31:0] eMag; logic eDet; peakEv_t p;
    randomFrame();
    for (int k = 0; k <= 12; k++) driveCycle(1'b1, frRe[k], frIm[k], 1'b0);
    @(negedge clk);
    busA.in_valid = 1'b0;
    busB.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busA.mag_valid, busA.peak_valid, busA.peak_mag, busA.det, busyA,
         busB.mag_valid, busB.peak_valid, busB.peak_mag, busB.det, busyB} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0", {busA.mag_valid, busA.peak_valid,
               busA.peak_mag, busA.det, busyA, busB.mag_valid, busB.peak_valid, busB.peak_mag,
               busB.det, busyB});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    magQ.delete(); peakQ.delete();
    randomFrame();
    sendFrame(2);
    drain();
    for (int d = 0; d < 2; d++) begin
      refPeak(d, eIdx, eMag, eDet);
      p = peakAt(d, 0);
      checks++;
      if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
        errors++;
        $display("[TB] FAIL mid_reset_peak dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                 d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
      end
      checks++;
      if (magCount(d) != N || magAt(d, 0).idx != 0) begin
        errors++;
        $display("[TB] FAIL mid_reset_restart dut%0d: got n=%0d first=%0d expected n=%0d first=0",
                 d, magCount(d), magAt(d, 0).idx, N);
      end
    end
  endtask

  task automatic test_random();
    int eIdx; logic [31:0] eMag; logic eDet; magEv_t m; peakEv_t p;
    for (int f = 0; f < 12; f++) begin
      randomFrame();
      magQ.delete(); peakQ.delete();
      sendFrame((f % 2 == 0) ? 2 : 0);
      drain();
      for (int d = 0; d < 2; d++) begin
        refPeak(d, eIdx, eMag, eDet);
        checks++;
        if (magCount(d) != N) begin
          errors++;
          $display("[TB] FAIL rand_mag_count f%0d dut%0d: got %0d expected %0d", f, d, magCount(d), N);
        end
        for (int k = 0; k < N; k++) begin
          m = magAt(d, k);
          checks++;
          if (m.idx != k || m.mag !== refMag(k)) begin
            errors++;
            $display("[TB] FAIL rand_mag f%0d dut%0d bin%0d: got (%0d,%0d) expected (%0d,%0d)",
                     f, d, k, m.idx, m.mag, k, refMag(k));
          end
        end
        p = peakAt(d, 0);
        checks++;
        if (peakCount(d) != 1 || p.idx != eIdx || p.mag !== eMag || p.det !== eDet) begin
          errors++;
          $display("[TB] FAIL rand_peak f%0d dut%0d: got n=%0d (%0d,%0d,%b) expected n=1 (%0d,%0d,%b)",
                   f, d, peakCount(d), p.idx, p.mag, p.det, eIdx, eMag, eDet);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    clr           = 1'b0;
    busA.in_valid = 1'b0;
    busA.din_r    = '0;
    busA.din_i    = '0;
    busB.in_valid = 1'b0;
    busB.din_r    = '0;
    busB.din_i    = '0;
    test_reset();
    test_impulse();
    test_extreme_tie();
    test_gaps();
    test_back_to_back();
    test_clr();
    test_skip_dc();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
